// File: rtl/store_narrow_unit.sv
// Narrowing store unit: writes byte/halfword/word values into a word-wide memory
// without byte enables, using read-modify-write for sub-word stores (big-endian lanes).
module store_narrow_unit #(
  parameter int WL = 32,
  parameter int AW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [WL-1:0] req_data,
  input  logic [1:0]    req_size,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  input  logic [WL-1:0] mem_rdata,
  output logic          mem_we,
  output logic [WL-1:0] mem_wdata,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    MRG  = 3'd2,
    WR   = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic        accept_s;
  logic        bad_req_s;
  logic [1:0]  off_r;
  logic [1:0]  size_r;
  logic [15:0] data_r;
  logic [WL-1:0] merged_s;

  // Reserved size or a halfword/word not aligned to its own width.
  function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Replace the addressed lane of the old word; lane 0 is the most significant byte.
  function automatic logic [WL-1:0] merge_lane(input logic [1:0] size,
                                               input logic [1:0] off,
                                               input logic [15:0] src,
                                               input logic [WL-1:0] old);
    logic [WL-1:0] m;
    m = old;
    case (size)
      2'b00: begin
        case (off)
          2'b00:   m[31:24] = src[7:0];
          2'b01:   m[23:16] = src[7:0];
          2'b10:   m[15:8]  = src[7:0];
          default: m[7:0]   = src[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) begin
          m[15:0] = src;
        end else begin
          m[31:16] = src;
        end
      end
      default: m = old;
    endcase
    return m;
  endfunction

  assign accept_s  = (state_r == IDLE) && req_valid;
  assign bad_req_s = is_bad_req(req_size, req_addr[1:0]);
  assign merged_s  = merge_lane(size_r, off_r, data_r, mem_rdata);

  // Next-state selection.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!req_valid) begin
          next_state_s = IDLE;
        end else if (bad_req_s) begin
          next_state_s = ERR;
        end else if (req_size == 2'b10) begin
          next_state_s = WR;
        end else begin
          next_state_s = RD;
        end
      end
      RD:      next_state_s = MRG;
      MRG:     next_state_s = WR;
      WR:      next_state_s = IDLE;
      ERR:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, request latches and strobes; strobes are registered from the next state
  // so each is high for exactly the cycle its state is occupied.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= IDLE;
      req_ready <= 1'b1;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_addr  <= {AW{1'b0}};
      mem_wdata <= {WL{1'b0}};
      off_r     <= 2'b00;
      size_r    <= 2'b00;
      data_r    <= 16'h0000;
    end else begin
      state_r   <= next_state_s;
      req_ready <= (next_state_s == IDLE);
      mem_re    <= (next_state_s == RD);
      mem_we    <= (next_state_s == WR);
      done      <= (next_state_s == WR);
      err       <= (next_state_s == ERR);
      if (accept_s) begin
        mem_addr <= {req_addr[AW-1:2], 2'b00};
        off_r    <= req_addr[1:0];
        size_r   <= req_size;
        data_r   <= req_data[15:0];
      end else begin
        mem_addr <= mem_addr;
        off_r    <= off_r;
        size_r   <= size_r;
        data_r   <= data_r;
      end
      if (accept_s && (next_state_s == WR)) begin
        mem_wdata <= req_data;
      end else if (state_r == MRG) begin
        mem_wdata <= merged_s;
      end else begin
        mem_wdata <= mem_wdata;
      end
    end
  end

endmodule
